// File: rtl/icache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | icache_pkg : shared types and constants for the icache_resp slice   |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int DEF_NUM_LINES      = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | icache_array : valid/tag/data storage, one async read, one sync     |
// |                write port (word write + tag/valid set)              |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module icache_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int IDX_W = $clog2(NUM_LINES),
  localparam int OFF_W = $clog2(WORDS_PER_LINE),
  localparam int TAG_W = 30 - IDX_W - OFF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [31:0]      wr_data,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_index,
  input  logic [TAG_W-1:0] set_tag
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];
  logic [31:0]          data_d [NUM_LINES][WORDS_PER_LINE];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_offset];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (set_en) begin
      valid_d[set_index] = 1'b1;
      tag_d[set_index]   = set_tag;
    end
    if (wr_en) begin
      data_d[wr_index][wr_offset] = wr_data;
    end
  end

  // Only the valid bits are reset; stale tag/data are masked by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule
`default_nettype wire

// File: rtl/icache_resp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | icache_resp : direct-mapped read-only I-cache, line refill from     |
// |               backing memory; ICACHE_STATS_EN enables hit/miss cnt  |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
module icache_resp
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_ready,
  input  logic [31:0] addr,
  output logic        cache_ack,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = 30 - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;

  logic [OFF_W-1:0] req_off, lat_off, rd_offset;
  logic [IDX_W-1:0] req_idx, lat_idx, rd_index;
  logic [TAG_W-1:0] req_tag, lat_tag, rd_tag;
  logic             rd_valid;
  logic [31:0]      rd_data;
  logic             in_idle, req_hit, req_miss, beat, last_beat;
  logic             unused_addr_bits;

  assign req_off = addr[2 +: OFF_W];
  assign req_idx = addr[2 + OFF_W +: IDX_W];
  assign req_tag = addr[31 -: TAG_W];
  assign lat_off = addr_q[2 +: OFF_W];
  assign lat_idx = addr_q[2 + OFF_W +: IDX_W];
  assign lat_tag = addr_q[31 -: TAG_W];

  assign unused_addr_bits = ^{addr[1:0], addr_q[1:0]};

  // Live address is looked up in IDLE; the latched one while refilling/responding.
  assign in_idle   = (state_q == IDLE);
  assign rd_index  = in_idle ? req_idx : lat_idx;
  assign rd_offset = in_idle ? req_off : lat_off;

  assign req_hit   = in_idle && addr_ready && rd_valid && (rd_tag == req_tag);
  assign req_miss  = in_idle && addr_ready && !req_hit;
  assign beat      = (state_q == REFILL) && mem_req_q && mem_ack;
  assign last_beat = beat && (cnt_q == LAST_WORD);

  assign cache_ack = req_hit || (state_q == RESPOND);
  assign inst      = cache_ack ? rd_data : NOP_INST;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

  icache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (rd_index),
    .rd_offset (rd_offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (beat),
    .wr_index  (lat_idx),
    .wr_offset (cnt_q),
    .wr_data   (mem_rdata),
    .set_en    (last_beat),
    .set_index (lat_idx),
    .set_tag   (lat_tag)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      IDLE: begin
        if (req_miss) begin
          state_d = REFILL;
          addr_d  = addr;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        // First REFILL cycle loads the request flops from the latched line address.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {addr_q[31:2+OFF_W], cnt_q, 2'b00};
        end else if (beat) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (last_beat) begin
            mem_req_d = 1'b0;
            state_d   = RESPOND;
          end else begin
            mem_addr_d = {addr_q[31:2+OFF_W], cnt_d, 2'b00};
          end
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Saturating event counters.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (req_hit && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (req_miss && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_resp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_icache_resp : randomized self-checking bench for icache_resp     |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module tb_icache_resp;

  localparam int NUM_LINES  = 16;
  localparam int WORDS      = 4;
  localparam int LINE_BYTES = 4 * WORDS;
  localparam int MISS_LAT   = WORDS + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_ready;
  logic [31:0] addr;
  logic        cache_ack;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        mem_go;
  logic        mem_spur;

  int checks = 0;
  int errors = 0;

  // Model: which tag each line holds, plus event counts.
  bit          m_valid [NUM_LINES];
  int unsigned m_tag   [NUM_LINES];
  int unsigned m_hits, m_misses;

  logic        obs_ack0, obs_req0, obs_f_ack;
  logic [31:0] obs_inst0, obs_inst, obs_f_inst;
  int          obs_lat, obs_acks, obs_stalls;
  logic [31:0] beat_addrs[$];

  icache_resp #(.NUM_LINES(NUM_LINES), .WORDS_PER_LINE(WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_ready (addr_ready),
    .addr       (addr),
    .cache_ack  (cache_ack),
    .inst       (inst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w >= 32'h40 && w < 32'h50) return 32'hA0 + (w - 32'h40) / 4;
    return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign mem_ack   = (mem_req & mem_go) | mem_spur;
  assign mem_rdata = mem_data(mem_addr);

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a - (a % LINE_BYTES);
  endfunction

  function automatic bit model_access(input logic [31:0] a);
    int unsigned i, t;
    bit h;
    i = (a / LINE_BYTES) % NUM_LINES;
    t = a / (LINE_BYTES * NUM_LINES);
    h = m_valid[i] && (m_tag[i] == t);
    if (h) m_hits++;
    else begin
      m_misses++;
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
    end
    return h;
  endfunction

  function automatic void model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endfunction

  // One request; records what the DUT did until two cycles past its first ack.
  task automatic issue(input logic [31:0] a, input bit stall_en, input int stray_cyc,
                       input logic [31:0] stray_addr, input bit follow_en,
                       input logic [31:0] follow_addr);
    beat_addrs.delete();
    obs_lat = -1; obs_acks = 0; obs_stalls = 0;
    obs_f_ack = 1'b0; obs_f_inst = '0; obs_inst = NOP;
    @(negedge clk);
    mem_go = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    addr_ready = 1'b1;
    addr = a;
    #1;
    obs_ack0 = cache_ack; obs_inst0 = inst; obs_req0 = mem_req;
    if (cache_ack) begin obs_lat = 0; obs_inst = inst; obs_acks = 1; end
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      mem_go = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      addr_ready = 1'b0;
      if (c == stray_cyc) begin addr_ready = 1'b1; addr = stray_addr; end
      if (follow_en && obs_lat >= 0 && c == obs_lat + 1) begin
        addr_ready = 1'b1; addr = follow_addr;
      end
      #1;
      if (mem_req && mem_ack) beat_addrs.push_back(mem_addr);
      if (mem_req && !mem_ack) obs_stalls++;
      if (follow_en && obs_lat >= 0 && c == obs_lat + 1) begin
        obs_f_ack = cache_ack; obs_f_inst = inst;
      end else if (cache_ack) begin
        obs_acks++;
        if (obs_lat < 0) begin obs_lat = c; obs_inst = inst; end
      end
      if (obs_lat >= 0 && c >= obs_lat + 2) break;
    end
    addr_ready = 1'b0;
    mem_go = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; addr_ready = 1'b1; addr = 32'h0; mem_go = 1'b1; mem_spur = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (cache_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", cache_ack); end
    checks++; if (inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", inst, NOP); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count);
    end
    @(negedge clk);
    addr_ready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    bit exp_hit;
    exp_hit = model_access(32'h40);
    issue(32'h40, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_ack0 !== exp_hit) begin errors++; $display("FAIL cold_ack0: got %b want %b", obs_ack0, exp_hit); end
    checks++; if (obs_lat != MISS_LAT) begin errors++; $display("FAIL cold_latency: got %0d want %0d", obs_lat, MISS_LAT); end
    checks++; if (obs_inst !== 32'hA0) begin errors++; $display("FAIL cold_inst: got %h want 000000a0", obs_inst); end
    checks++; if (obs_acks != 1) begin errors++; $display("FAIL cold_ack_count: got %0d want 1", obs_acks); end
    checks++;
    if (beat_addrs.size() != WORDS) begin
      errors++; $display("FAIL cold_beats: got %0d beats want %0d", beat_addrs.size(), WORDS);
    end else begin
      for (int k = 0; k < WORDS; k++) begin
        if (beat_addrs[k] !== 32'h40 + 32'(4 * k)) begin
          errors++; $display("FAIL cold_mem_addr[%0d]: got %h want %h", k, beat_addrs[k], 32'h40 + 32'(4 * k));
          break;
        end
      end
    end
  endtask

  task automatic test_hit();
    bit exp_hit;
    exp_hit = model_access(32'h48);
    issue(32'h48, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_ack0 !== exp_hit) begin errors++; $display("FAIL hit_ack: got %b want %b", obs_ack0, exp_hit); end
    checks++; if (obs_inst0 !== 32'hA2) begin errors++; $display("FAIL hit_inst: got %h want 000000a2", obs_inst0); end
    checks++; if (obs_req0 !== 1'b0) begin errors++; $display("FAIL hit_mem_req: got %b want 0", obs_req0); end
    checks++; if (obs_acks != 1) begin errors++; $display("FAIL hit_ack_count: got %0d want 1", obs_acks); end
  endtask

  task automatic test_conflict();
    bit exp_hit;
    exp_hit = model_access(32'h440);
    issue(32'h440, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_ack0 !== exp_hit) begin errors++; $display("FAIL conflict_ack0: got %b want %b", obs_ack0, exp_hit); end
    checks++; if (obs_lat != MISS_LAT) begin errors++; $display("FAIL conflict_latency: got %0d want %0d", obs_lat, MISS_LAT); end
    checks++; if (obs_inst !== mem_data(32'h440)) begin
      errors++; $display("FAIL conflict_inst: got %h want %h", obs_inst, mem_data(32'h440));
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp_h, exp_m;
`ifdef ICACHE_STATS_EN
    exp_h = m_hits; exp_m = m_misses;
`else
    exp_h = 32'h0; exp_m = 32'h0;
`endif
    checks++; if (hit_count !== exp_h) begin errors++; $display("FAIL stats_hits: got %0d want %0d", hit_count, exp_h); end
    checks++; if (miss_count !== exp_m) begin errors++; $display("FAIL stats_misses: got %0d want %0d", miss_count, exp_m); end
  endtask

  task automatic test_conflict_return();
    bit exp_hit;
    exp_hit = model_access(32'h40);
    issue(32'h40, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_ack0 !== exp_hit) begin errors++; $display("FAIL return_ack0: got %b want %b", obs_ack0, exp_hit); end
    checks++; if (obs_inst !== 32'hA0) begin errors++; $display("FAIL return_inst: got %h want 000000a0", obs_inst); end
  endtask

  task automatic test_ignored_strobe();
    bit exp_hit;
    void'(model_access(32'h440));
    issue(32'h440, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    exp_hit = model_access(32'h40);
    issue(32'h40, 1'b0, 2, 32'h80, 1'b0, 32'h0);
    checks++; if (obs_acks != 1 || exp_hit) begin errors++; $display("FAIL strobe_ack_count: got %0d want 1", obs_acks); end
    checks++; if (obs_inst !== 32'hA0) begin errors++; $display("FAIL strobe_inst: got %h want 000000a0", obs_inst); end
    checks++;
    if (beat_addrs.size() != WORDS || beat_addrs[WORDS-1] !== 32'h4C) begin
      errors++; $display("FAIL strobe_mem_addr: got %0d beats last %h want %0d beats last 0000004c",
                         beat_addrs.size(), (beat_addrs.size() > 0) ? beat_addrs[$] : 32'h0, WORDS);
    end
    exp_hit = model_access(32'h80);
    issue(32'h80, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_ack0 !== exp_hit) begin errors++; $display("FAIL strobe_not_latched: got %b want %b", obs_ack0, exp_hit); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, f;
    bit exp_first, exp_follow;
    a = 32'h3000_0010; f = 32'h3000_001C;
    exp_first  = model_access(a);
    exp_follow = model_access(f);
    issue(a, 1'b0, 0, 32'h0, 1'b1, f);
    checks++; if (obs_ack0 !== exp_first || obs_lat != MISS_LAT) begin
      errors++; $display("FAIL b2b_first: got ack0 %b lat %0d want %b lat %0d", obs_ack0, obs_lat, exp_first, MISS_LAT);
    end
    checks++; if (obs_f_ack !== exp_follow) begin errors++; $display("FAIL b2b_follow_ack: got %b want %b", obs_f_ack, exp_follow); end
    checks++; if (obs_f_inst !== mem_data(f)) begin errors++; $display("FAIL b2b_follow_inst: got %h want %h", obs_f_inst, mem_data(f)); end
  endtask

  task automatic test_reset_mid_refill();
    int n, c;
    bit bad;
    @(negedge clk);
    addr_ready = 1'b1; addr = 32'h840;
    @(negedge clk);
    addr_ready = 1'b0;
    n = 0; c = 0;
    while (n < 2 && c < 40) begin
      #1;
      if (mem_req && mem_ack) n++;
      c++;
      @(negedge clk);
    end
    checks++; if (n != 2) begin errors++; $display("FAIL midrst_two_beats: got %0d beats want 2", n); end
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || cache_ack !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: got mem_req %b ack %b want 0 0", mem_req, cache_ack);
    end
    model_reset();
    mem_spur = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      if (mem_req !== 1'b0 || cache_ack !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL midrst_spurious_ack: got activity want idle"); end
    mem_spur = 1'b0;
    void'(model_access(32'h40));
    issue(32'h40, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_ack0 !== 1'b0 || obs_lat != MISS_LAT) begin
      errors++; $display("FAIL midrst_refetch: got ack0 %b lat %0d want 0 lat %0d", obs_ack0, obs_lat, MISS_LAT);
    end
    checks++; if (beat_addrs.size() != WORDS || beat_addrs[0] !== 32'h40 || obs_inst !== 32'hA0) begin
      errors++; $display("FAIL midrst_word0: got %0d beats inst %h want %0d beats from 00000040 inst 000000a0",
                         beat_addrs.size(), obs_inst, WORDS);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, tagv, exp_inst;
    bit exp_hit, beats_ok;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: tagv = 32'h0;
        1: tagv = 32'h1;
        default: tagv = 32'h00FF_FFFF;
      endcase
      a = tagv * (LINE_BYTES * NUM_LINES) + 32'($urandom_range(0, 3)) * LINE_BYTES
          + 32'($urandom_range(0, WORDS - 1)) * 4 + 32'($urandom_range(0, 3));
      exp_hit  = model_access(a);
      exp_inst = mem_data(a);
      issue(a, 1'b1, 0, 32'h0, 1'b0, 32'h0);
      checks++; if (obs_ack0 !== exp_hit) begin errors++; $display("FAIL rand_hit[%0d] a=%h: got %b want %b", it, a, obs_ack0, exp_hit); end
      checks++; if (obs_acks != 1) begin errors++; $display("FAIL rand_acks[%0d]: got %0d want 1", it, obs_acks); end
      if (exp_hit) begin
        checks++; if (obs_inst0 !== exp_inst) begin errors++; $display("FAIL rand_hit_inst[%0d]: got %h want %h", it, obs_inst0, exp_inst); end
      end else begin
        checks++; if (obs_inst !== exp_inst) begin errors++; $display("FAIL rand_miss_inst[%0d]: got %h want %h", it, obs_inst, exp_inst); end
        checks++; if (obs_lat != MISS_LAT + obs_stalls) begin
          errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, obs_lat, MISS_LAT + obs_stalls);
        end
        beats_ok = (beat_addrs.size() == WORDS);
        if (beats_ok) begin
          for (int k = 0; k < WORDS; k++) begin
            if (beat_addrs[k] !== line_base(a) + 32'(4 * k)) beats_ok = 1'b0;
          end
        end
        checks++; if (!beats_ok) begin errors++; $display("FAIL rand_beats[%0d]: got %0d beats want %0d from %h", it, beat_addrs.size(), WORDS, line_base(a)); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_stats();
    test_conflict_return();
    test_ignored_strobe();
    test_back_to_back();
    test_reset_mid_refill();
    test_random();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
